fir_mac_multi: RTL

Parametrised, multi-channel, fixed-point FIR filter built around one time-multiplexed multiply-accumulate unit. It is the next-generation sample filter in the acquisition chain, sitting between the sample source (ADC/UART deframer) and the FFT/UART back end. It keeps the established newData/dataReady strobe handshake. It adds run-time coefficient loading, per-channel delay lines, convergent-free round-half-up scaling, saturation and overrun reporting.

---
 rtl/fir_mac_multi.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fir_mac_multi.sv
// Multi-channel fixed-point FIR filter with one shared, time-multiplexed MAC.
// Round-half-up scaling, output saturation and dropped-sample reporting.
module fir_mac_multi #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int CHANNELS  = 2,
  parameter int OUT_SHIFT = 14,
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS),
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inSignal,
  input  logic [CW-1:0]     inChannel,
  input  logic              newData,
  input  logic              coefWe,
  input  logic [AW-1:0]     coefAddr,
  input  logic [COEF_W-1:0] coefData,
  output logic [DATA_W-1:0] outSignal,
  output logic [CW-1:0]     outChannel,
  output logic              dataReady,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

  localparam logic [CW:0] CH_LIM = (CW+1)'(CHANNELS);
  localparam logic [AW:0] TAPS_X = (AW+1)'(TAPS);
  localparam logic signed [ACC_W:0] HALF =
    (ACC_W+1)'(1) <<< (OUT_SHIFT-1);
  localparam logic signed [ACC_W:0] MAXV =
    ((ACC_W+1)'(1) <<< (DATA_W-1)) - (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] MINV =
    -MAXV - (ACC_W+1)'(1);

  state_t state, stateNext;

  logic signed [COEF_W-1:0] coefMem [TAPS];
  logic signed [DATA_W-1:0] xMem [CHANNELS][TAPS];
  logic [AW-1:0]            wp [CHANNELS];
  logic [CW-1:0]            ch;
  logic [AW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;

  logic                     chValid;
  logic                     take;
  logic                     coefTake;
  logic                     lastTap;
  logic [AW:0]              tSum;
  logic [AW-1:0]            tIdx;
  logic signed [COEF_W+DATA_W-1:0] prod;
  logic signed [ACC_W:0]    accRnd;
  logic signed [ACC_W:0]    scaled;
  logic [DATA_W-1:0]        satOut;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    take      = 1'b0;
    coefTake  = 1'b0;
    chValid   = ({1'b0, inChannel} < CH_LIM);
    lastTap   = (k == AW'(TAPS-1));
    unique case (state)
      IDLE: begin
        coefTake = coefWe;
        if (newData && chValid) begin
          take      = 1'b1;
          stateNext = MAC;
        end
      end
      MAC:     if (lastTap) stateNext = ROUND;
      ROUND:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Tap k reads the sample written k acceptances ago on this channel.
  always_comb begin
    tSum = {1'b0, wp[ch]} + TAPS_X - {1'b0, k};
    tIdx = (tSum >= TAPS_X) ? AW'(tSum - TAPS_X) : AW'(tSum);
    prod = coefMem[k] * xMem[ch][tIdx];
    accRnd = (ACC_W+1)'(acc) + HALF;
    scaled = accRnd >>> OUT_SHIFT;
    if (scaled > MAXV)      satOut = DATA_W'(MAXV);
    else if (scaled < MINV) satOut = DATA_W'(MINV);
    else                    satOut = DATA_W'(scaled);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++)
        coefMem[t] <= '0;
      coefMem[0] <= COEF_W'(1 << OUT_SHIFT);
      for (int c = 0; c < CHANNELS; c++) begin
        wp[c] <= '0;
        for (int t = 0; t < TAPS; t++)
          xMem[c][t] <= '0;
      end
      ch         <= '0;
      k          <= '0;
      acc        <= '0;
      outSignal  <= '0;
      outChannel <= '0;
      dataReady  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dataReady <= 1'b0;
      overrun   <= newData && (busy || !chValid);
      if (coefTake)
        coefMem[coefAddr] <= coefData;
      if (take) begin
        xMem[inChannel][wp[inChannel]] <= inSignal;
        ch  <= inChannel;
        acc <= '0;
        k   <= '0;
      end
      if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        k   <= k + AW'(1);
      end
      if (state == ROUND) begin
        outSignal  <= satOut;
        outChannel <= ch;
        dataReady  <= 1'b1;
        if (wp[ch] == AW'(TAPS-1)) wp[ch] <= '0;
        else                       wp[ch] <= wp[ch] + AW'(1);
      end
    end
  end

endmodule
